// File: rtl/fft_axis_out_buffer.sv
// Buffers native FFT output frames in a first-word-fall-through FIFO and replays them as an
// AXI4-Stream master with per-frame TLAST and sticky overflow / frame-error flags.
module fft_axis_out_buffer #(
   parameter int DATA_BITS      = 18,
   parameter int AXI4S_OUT_DATA = 24,
   parameter int FFT_SIZE       = 256,
   parameter int DEPTH          = 512
) (
   input  logic                          CLK,
   input  logic                          NGRST,
   input  logic [DATA_BITS-1:0]          DATAO_RE,
   input  logic [DATA_BITS-1:0]          DATAO_IM,
   input  logic                          DATAO_VALID,
   input  logic                          OUTP_READY,
   input  logic                          CLR_FLAGS,
   output logic                          AXI4_M_DATAO_TVALID,
   input  logic                          AXI4_M_DATAO_TREADY,
   output logic [2*AXI4S_OUT_DATA-1:0]   AXI4_M_TDATAO,
   output logic                          AXI4_M_TLASTO,
   output logic                          OVFLOW,
   output logic                          FRAME_ERR,
   output logic [$clog2(DEPTH):0]        FILL_LEVEL
);

   localparam int CNT_W = $clog2(FFT_SIZE);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENT_W = 2 * DATA_BITS + 1;

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_next;
   logic [LVL_W-1:0] count;
   logic [CNT_W-1:0] scnt;
   logic [CNT_W-1:0] idx;
   logic [ENT_W-1:0] head;
   logic [ENT_W-1:0] in_entry;
   logic             in_last;
   logic             pop;
   logic             push_ok;

   always_comb begin
      idx      = OUTP_READY ? '0 : scnt;
      in_last  = (idx == CNT_W'(FFT_SIZE - 1));
      in_entry = {in_last, DATAO_IM, DATAO_RE};
      pop      = (count != '0) && AXI4_M_DATAO_TREADY;
      push_ok  = DATAO_VALID && ((count != LVL_W'(DEPTH)) || pop);
      rd_next  = rd_ptr + 1'b1;
   end

   // Storage array carries no reset so it can map onto RAM; pointers alone define validity.
   always_ff @(posedge CLK) begin
      if (push_ok)
         mem[wr_ptr] <= in_entry;
   end

   // The head register mirrors the oldest entry so outputs stay put while stalled or empty.
   always_ff @(posedge CLK) begin
      if (!NGRST) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         scnt      <= '0;
         head      <= '0;
         OVFLOW    <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_next;
         count <= count + LVL_W'(push_ok) - LVL_W'(pop);

         if (pop) begin
            if (count == LVL_W'(1)) begin
               if (push_ok)
                  head <= in_entry;
            end else begin
               head <= mem[rd_next];
            end
         end else if ((count == '0) && push_ok) begin
            head <= in_entry;
         end

         // Dropped samples still advance the index so later frames keep TLAST aligned.
         if (OUTP_READY)
            scnt <= CNT_W'(DATAO_VALID);
         else if (DATAO_VALID)
            scnt <= scnt + 1'b1;

         if (DATAO_VALID && !push_ok)
            OVFLOW <= 1'b1;
         else if (CLR_FLAGS)
            OVFLOW <= 1'b0;

         if (OUTP_READY && (scnt != '0))
            FRAME_ERR <= 1'b1;
         else if (CLR_FLAGS)
            FRAME_ERR <= 1'b0;
      end
   end

   always_comb begin
      AXI4_M_DATAO_TVALID = (count != '0);
      AXI4_M_TLASTO       = head[ENT_W-1];
      AXI4_M_TDATAO       = {AXI4S_OUT_DATA'($signed(head[2*DATA_BITS-1:DATA_BITS])),
                             AXI4S_OUT_DATA'($signed(head[DATA_BITS-1:0]))};
      FILL_LEVEL          = count;
   end

endmodule
